// File: rtl/if_queue_pred_if.sv
// Fetch-unit bus bundle: byte-serial memory port toward the arbiter plus the
// valid/ready instruction stream toward the decoder.
interface if_queue_pred_if;
    logic        mem_busy;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_pc;

    modport master (
        input  mem_busy, mem_din, out_ready,
        output mem_a, mem_wr, out_valid, out_ins, out_pc, out_pred_taken, out_pred_pc
    );

    modport slave (
        output mem_busy, mem_din, out_ready,
        input  mem_a, mem_wr, out_valid, out_ins, out_pc, out_pred_taken, out_pred_pc
    );
endinterface

// File: rtl/if_queue_pred.sv
// Byte-serial instruction fetch with a DEPTH-entry first-word-fall-through queue
// and static JAL predecode; the ROB repairs mispredictions through clear/jump_pc.
module if_queue_pred #(
    parameter int unsigned QUEUE_AW    = 2,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter bit          PREDICT_JAL = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear,
    input  logic [31:0]     jump_pc,
    if_queue_pred_if.master bus
);

    localparam int unsigned       DEPTH      = 2 ** QUEUE_AW;
    localparam logic [QUEUE_AW:0] FULL_COUNT = {1'b1, {QUEUE_AW{1'b0}}};
    localparam logic [QUEUE_AW:0] LAST_FREE  = FULL_COUNT - 1'b1;

    typedef enum logic [2:0] {IDLE, BYTE1, BYTE2, BYTE3, BYTE4} fetch_state_t;

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] mem_a_q;
    logic [31:0] mem_a_next;
    logic [7:0]  byte0, byte1, byte2;

    logic [31:0] q_ins       [DEPTH];
    logic [31:0] q_pc        [DEPTH];
    logic [31:0] q_pred_pc   [DEPTH];
    logic        q_pred_taken[DEPTH];

    logic [QUEUE_AW-1:0] head, tail;
    logic [QUEUE_AW:0]   count;

    logic        has_room, room_after_push;
    logic        load_mem_a, cap0, cap1, cap2, push, pop;
    logic        out_valid;
    logic [31:0] ins, jal_imm, pred_pc;
    logic        pred_taken;

    // Byte 3 is consumed straight from the port on the completing cycle.
    assign ins        = {bus.mem_din, byte2, byte1, byte0};
    assign jal_imm    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign pred_taken = PREDICT_JAL && (ins[6:0] == 7'b1101111);
    assign pred_pc    = pred_taken ? pc + jal_imm : pc + 32'd4;

    assign has_room        = (count != FULL_COUNT);
    assign room_after_push = (count < LAST_FREE);

    assign out_valid = rdy_in && (count != '0);
    assign pop       = out_valid && bus.out_ready && !clear;

    assign bus.out_valid      = out_valid;
    assign bus.out_ins        = q_ins[head];
    assign bus.out_pc         = q_pc[head];
    assign bus.out_pred_taken = q_pred_taken[head];
    assign bus.out_pred_pc    = q_pred_pc[head];
    assign bus.mem_a          = mem_a_q;
    assign bus.mem_wr         = 1'b0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= clear ? IDLE : state_next;
        end
    end

    // Losing the port mid-instruction drops every collected byte; refetch from byte 0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.mem_busy && has_room) state_next = BYTE1;
            BYTE1:   state_next = bus.mem_busy ? IDLE : BYTE2;
            BYTE2:   state_next = bus.mem_busy ? IDLE : BYTE3;
            BYTE3:   state_next = bus.mem_busy ? IDLE : BYTE4;
            BYTE4:   state_next = (!bus.mem_busy && room_after_push) ? BYTE1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_mem_a = 1'b0;
        mem_a_next = mem_a_q;
        cap0       = 1'b0;
        cap1       = 1'b0;
        cap2       = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: if (!bus.mem_busy && has_room) begin
                load_mem_a = 1'b1;
                mem_a_next = pc;
            end
            BYTE1: if (!bus.mem_busy) begin
                cap0       = 1'b1;
                load_mem_a = 1'b1;
                mem_a_next = pc + 32'd1;
            end
            BYTE2: if (!bus.mem_busy) begin
                cap1       = 1'b1;
                load_mem_a = 1'b1;
                mem_a_next = pc + 32'd2;
            end
            BYTE3: if (!bus.mem_busy) begin
                cap2       = 1'b1;
                load_mem_a = 1'b1;
                mem_a_next = pc + 32'd3;
            end
            BYTE4: if (!bus.mem_busy) begin
                push = 1'b1;
                if (room_after_push) begin
                    load_mem_a = 1'b1;
                    mem_a_next = pred_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc      <= RESET_PC;
            mem_a_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                pc    <= jump_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (load_mem_a) mem_a_q <= mem_a_next;
                if (push) begin
                    tail <= tail + 1'b1;
                    pc   <= pred_pc;
                end
                if (pop) head <= head + 1'b1;
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (!push && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !clear) begin
            if (cap0) byte0 <= bus.mem_din;
            if (cap1) byte1 <= bus.mem_din;
            if (cap2) byte2 <= bus.mem_din;
            if (push) begin
                q_ins[tail]        <= ins;
                q_pc[tail]         <= pc;
                q_pred_taken[tail] <= pred_taken;
                q_pred_pc[tail]    <= pred_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_queue_pred.sv
// Bench for if_queue_pred: directed scenarios plus a randomized run scored
// against a program-order model that walks memory along the predicted path.
module tb_if_queue_pred;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic [31:0] jump_pc;
    logic [7:0]  garbage;
    logic [7:0]  mem [1024];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_queue_pred_if bus_main ();
    if_queue_pred_if bus_nojal ();

    // Memory answers combinationally for the address the DUT is holding; while
    // the LSB owns the port the byte lane carries unrelated data.
    assign bus_main.mem_din   = bus_main.mem_busy ? garbage : mem[bus_main.mem_a[9:0]];
    assign bus_nojal.mem_din  = mem[bus_nojal.mem_a[9:0]];
    assign bus_nojal.mem_busy = 1'b0;
    assign bus_nojal.out_ready = 1'b1;

    if_queue_pred #(.QUEUE_AW(2), .RESET_PC(32'h0), .PREDICT_JAL(1'b1)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clear  (clear),
        .jump_pc(jump_pc),
        .bus    (bus_main)
    );

    if_queue_pred #(.QUEUE_AW(2), .RESET_PC(32'h0), .PREDICT_JAL(1'b0)) dut_nojal (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clear  (clear),
        .jump_pc(jump_pc),
        .bus    (bus_nojal)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] a0, a1, a2, a3;
        a0 = a; a1 = a + 32'd1; a2 = a + 32'd2; a3 = a + 32'd3;
        return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a0[9:0]]};
    endfunction

    function automatic void set_word(input logic [31:0] a, input logic [31:0] w);
        for (int unsigned k = 0; k < 4; k++) mem[(a[9:0] + 10'(k))] = w[8*k +: 8];
    endfunction

    function automatic bit model_taken(input logic [31:0] ins, input bit predict);
        return predict && (ins[6:0] == 7'h6F);
    endfunction

    // JAL offset rebuilt from its field weights, sign bit worth -2^20.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input bit predict);
        int off;
        if (model_taken(ins, predict)) begin
            off = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096;
            if (ins[31]) off = off - 1048576;
            return pc + 32'(off);
        end
        return pc + 32'd4;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_program;
        for (int unsigned i = 0; i < 256; i++) set_word(32'(i * 4), 32'h0000_0013);
        set_word(32'h00, 32'h0050_0093);
        set_word(32'h04, 32'h0010_0113);
        set_word(32'h08, 32'h0020_8193);
        set_word(32'h0C, 32'h0031_0213);
        set_word(32'h10, 32'h0100_006F);
        set_word(32'h14, 32'h0040_0293);
        set_word(32'h20, 32'h0060_0313);
        set_word(32'h100, 32'h00A0_0513);
    endtask

    task automatic do_reset(input bit ready);
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; jump_pc = '0;
        bus_main.mem_busy = 1'b0; bus_main.out_ready = ready; garbage = 8'hA5;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        load_program;
        rst = 1'b1; rdy = 1'b0; clear = 1'b0; jump_pc = '0;
        bus_main.mem_busy = 1'b0; bus_main.out_ready = 1'b1; garbage = 8'hA5;
        tick; tick;
        checks++;
        if ({bus_main.mem_a, bus_main.mem_wr, bus_main.out_valid} !== {32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: mem_a=%h mem_wr=%b valid=%b expected 0/0/0",
                     bus_main.mem_a, bus_main.mem_wr, bus_main.out_valid);
        end
        rdy = 1'b1;
        rst = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick;
            checks++;
            if ({bus_main.out_valid, bus_main.mem_a} !== {1'b0, 32'(k)}) begin
                errors++;
                $display("FAIL first_fetch_addr%0d: valid=%b mem_a=%h expected 0/%h",
                         k, bus_main.out_valid, bus_main.mem_a, 32'(k));
            end
        end
        tick;
        checks++;
        if ({bus_main.out_valid, bus_main.out_ins, bus_main.out_pc, bus_main.out_pred_taken,
             bus_main.out_pred_pc, bus_main.mem_a} !==
            {1'b1, 32'h0050_0093, 32'h0, 1'b0, 32'h4, 32'h4}) begin
            errors++;
            $display("FAIL first_push: valid=%b ins=%h pc=%h tk=%b ppc=%h mem_a=%h expected 1/00500093/0/0/4/4",
                     bus_main.out_valid, bus_main.out_ins, bus_main.out_pc,
                     bus_main.out_pred_taken, bus_main.out_pred_pc, bus_main.mem_a);
        end
    endtask

    task automatic test_jal;
        bit seen_a, seen_b, next_a, next_b;
        do_reset(1'b1);
        seen_a = 0; seen_b = 0; next_a = 0; next_b = 0;
        for (int n = 0; n < 80 && !(next_a && next_b); n++) begin
            tick;
            if (bus_main.out_valid && seen_a && !next_a) begin
                next_a = 1; checks++;
                if (bus_main.out_pc !== 32'h20) begin
                    errors++;
                    $display("FAIL jal_follow_pc: got %h expected 00000020", bus_main.out_pc);
                end
            end
            if (bus_main.out_valid && bus_main.out_pc === 32'h10 && !seen_a) begin
                seen_a = 1; checks++;
                if ({bus_main.out_ins, bus_main.out_pred_taken, bus_main.out_pred_pc, bus_main.mem_a}
                    !== {32'h0100_006F, 1'b1, 32'h20, 32'h20}) begin
                    errors++;
                    $display("FAIL jal_predict: ins=%h tk=%b ppc=%h mem_a=%h expected 0100006f/1/20/20",
                             bus_main.out_ins, bus_main.out_pred_taken, bus_main.out_pred_pc,
                             bus_main.mem_a);
                end
            end
            if (bus_nojal.out_valid && seen_b && !next_b) begin
                next_b = 1; checks++;
                if (bus_nojal.out_pc !== 32'h14) begin
                    errors++;
                    $display("FAIL nojal_follow_pc: got %h expected 00000014", bus_nojal.out_pc);
                end
            end
            if (bus_nojal.out_valid && bus_nojal.out_pc === 32'h10 && !seen_b) begin
                seen_b = 1; checks++;
                if ({bus_nojal.out_pred_taken, bus_nojal.out_pred_pc, bus_nojal.mem_a}
                    !== {1'b0, 32'h14, 32'h14}) begin
                    errors++;
                    $display("FAIL nojal_fallthrough: tk=%b ppc=%h mem_a=%h expected 0/14/14",
                             bus_nojal.out_pred_taken, bus_nojal.out_pred_pc, bus_nojal.mem_a);
                end
            end
        end
        checks++;
        if (!(next_a && next_b)) begin
            errors++;
            $display("FAIL jal_timeout: seen=%b%b next=%b%b expected all 1", seen_a, seen_b, next_a, next_b);
        end
    endtask

    task automatic test_full;
        logic [31:0] exp_pc [4];
        int n;
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) tick;
        checks++;
        if ({bus_main.out_valid, bus_main.out_pc, bus_main.mem_a} !== {1'b1, 32'h0, 32'hF}) begin
            errors++;
            $display("FAIL full_hold: valid=%b pc=%h mem_a=%h expected 1/0/f",
                     bus_main.out_valid, bus_main.out_pc, bus_main.mem_a);
        end
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (bus_main.mem_a !== 32'hF) begin
            errors++;
            $display("FAIL full_no_issue: mem_a=%h expected 0000000f", bus_main.mem_a);
        end
        bus_main.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus_main.out_valid, bus_main.out_pc, bus_main.out_ins}
                !== {1'b1, exp_pc[i], word_at(exp_pc[i])}) begin
                errors++;
                $display("FAIL drain%0d: valid=%b pc=%h ins=%h expected 1/%h/%h", i,
                         bus_main.out_valid, bus_main.out_pc, bus_main.out_ins,
                         exp_pc[i], word_at(exp_pc[i]));
            end
            if (i == 2) begin
                checks++;
                if (bus_main.mem_a !== 32'h10) begin
                    errors++;
                    $display("FAIL resume_addr: mem_a=%h expected 00000010", bus_main.mem_a);
                end
            end
            tick;
        end
        checks++;
        if (bus_main.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained_empty: valid=%b expected 0", bus_main.out_valid);
        end
        n = 0;
        while (bus_main.out_valid !== 1'b1 && n < 20) begin tick; n++; end
        checks++;
        if ({bus_main.out_valid, bus_main.out_pc} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL resume_push: valid=%b pc=%h expected 1/10", bus_main.out_valid, bus_main.out_pc);
        end
    endtask

    task automatic test_busy;
        int n, seen8;
        do_reset(1'b1);
        n = 0;
        while (bus_main.mem_a !== 32'h9 && n < 40) begin tick; n++; end
        checks++;
        if (bus_main.mem_a !== 32'h9) begin
            errors++;
            $display("FAIL busy_setup: mem_a=%h expected 00000009", bus_main.mem_a);
        end
        bus_main.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (bus_main.mem_a !== 32'h9 || (bus_main.out_valid && bus_main.out_pc === 32'h8)) begin
                errors++;
                $display("FAIL busy_hold%0d: mem_a=%h valid=%b pc=%h expected mem_a 9 and no pc 8",
                         i, bus_main.mem_a, bus_main.out_valid, bus_main.out_pc);
            end
        end
        bus_main.mem_busy = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (bus_main.mem_a !== 32'h8 + 32'(k)) begin
                errors++;
                $display("FAIL busy_refetch%0d: mem_a=%h expected %h", k, bus_main.mem_a, 32'h8 + 32'(k));
            end
        end
        tick;
        checks++;
        if ({bus_main.out_valid, bus_main.out_pc, bus_main.out_ins} !== {1'b1, 32'h8, word_at(32'h8)}) begin
            errors++;
            $display("FAIL busy_push: valid=%b pc=%h ins=%h expected 1/8/%h",
                     bus_main.out_valid, bus_main.out_pc, bus_main.out_ins, word_at(32'h8));
        end
        seen8 = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus_main.out_valid && bus_main.out_pc === 32'h8) seen8++;
        end
        checks++;
        if (seen8 != 0) begin
            errors++;
            $display("FAIL busy_duplicate: extra pc8 entries=%0d expected 0", seen8);
        end
    endtask

    task automatic test_clear;
        int n;
        do_reset(1'b0);
        n = 0;
        while (bus_main.mem_a !== 32'hD && n < 40) begin tick; n++; end
        checks++;
        if ({bus_main.mem_a, bus_main.out_valid, bus_main.out_pc} !== {32'hD, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL clear_setup: mem_a=%h valid=%b pc=%h expected d/1/0",
                     bus_main.mem_a, bus_main.out_valid, bus_main.out_pc);
        end
        clear = 1'b1; jump_pc = 32'h100;
        tick;
        clear = 1'b0;
        checks++;
        if (bus_main.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush: valid=%b expected 0", bus_main.out_valid);
        end
        tick;
        checks++;
        if (bus_main.mem_a !== 32'h100) begin
            errors++;
            $display("FAIL clear_restart: mem_a=%h expected 00000100", bus_main.mem_a);
        end
        bus_main.out_ready = 1'b1;
        n = 0;
        while (bus_main.out_valid !== 1'b1 && n < 20) begin tick; n++; end
        checks++;
        if ({bus_main.out_valid, bus_main.out_pc, bus_main.out_ins} !== {1'b1, 32'h100, word_at(32'h100)}) begin
            errors++;
            $display("FAIL clear_first: valid=%b pc=%h ins=%h expected 1/100/%h",
                     bus_main.out_valid, bus_main.out_pc, bus_main.out_ins, word_at(32'h100));
        end
    endtask

    task automatic test_rdy;
        int n;
        do_reset(1'b1);
        n = 0;
        while (bus_main.mem_a !== 32'h5 && n < 40) begin tick; n++; end
        rdy = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus_main.out_valid, bus_main.mem_a} !== {1'b0, 32'h5}) begin
                errors++;
                $display("FAIL rdy_freeze%0d: valid=%b mem_a=%h expected 0/5", i,
                         bus_main.out_valid, bus_main.mem_a);
            end
            tick;
        end
        rdy = 1'b1;
        n = 0;
        while (bus_main.out_valid !== 1'b1 && n < 20) begin tick; n++; end
        checks++;
        if ({bus_main.out_valid, bus_main.out_pc, bus_main.out_ins} !== {1'b1, 32'h4, word_at(32'h4)}) begin
            errors++;
            $display("FAIL rdy_resume: valid=%b pc=%h ins=%h expected 1/4/%h",
                     bus_main.out_valid, bus_main.out_pc, bus_main.out_ins, word_at(32'h4));
        end
    endtask

    task automatic test_random;
        logic [31:0] mpc, exp_ins, exp_next, w;
        logic [20:0] imm21;
        bit          exp_tk;
        int          off, pops, bad;
        for (int unsigned i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                off   = (int'($urandom_range(0, 511)) - 256) * 2;
                imm21 = 21'(off);
                w     = {imm21[20], imm21[10:1], imm21[11], imm21[19:12], 5'($urandom), 7'h6F};
            end
            set_word(32'(i * 4), w);
        end
        do_reset(1'b1);
        mpc = 32'h0; pops = 0; bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus_main.mem_busy  = ($urandom_range(0, 9) == 0);
            bus_main.out_ready = ($urandom_range(0, 9) < 7);
            rdy                = ($urandom_range(0, 9) != 0);
            clear              = ($urandom_range(0, 49) == 0);
            jump_pc            = $urandom;
            garbage            = 8'($urandom);
            #1;
            exp_ins  = word_at(mpc);
            exp_tk   = model_taken(exp_ins, 1'b1);
            exp_next = model_next(mpc, exp_ins, 1'b1);
            if (bus_main.out_valid === 1'b1) begin
                checks++;
                if ({bus_main.out_ins, bus_main.out_pc, bus_main.out_pred_taken, bus_main.out_pred_pc}
                    !== {exp_ins, mpc, exp_tk, exp_next}) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL rand_head@%0d: ins=%h pc=%h tk=%b ppc=%h expected %h/%h/%b/%h",
                                 cyc, bus_main.out_ins, bus_main.out_pc, bus_main.out_pred_taken,
                                 bus_main.out_pred_pc, exp_ins, mpc, exp_tk, exp_next);
                end
            end
            if (rdy && clear) begin
                mpc = jump_pc;
            end else if (bus_main.out_valid === 1'b1 && bus_main.out_ready) begin
                mpc = exp_next;
                pops++;
            end
            tick;
        end
        clear = 1'b0; rdy = 1'b1;
        checks++;
        if (pops < 50) begin
            errors++;
            $display("FAIL rand_progress: pops=%0d expected at least 50", pops);
        end
        checks++;
        if (bus_main.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL mem_wr_zero: got %b expected 0", bus_main.mem_wr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_jal;
        load_program;
        test_full;
        test_busy;
        test_clear;
        test_rdy;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
